riscv_lsu: RTL and testbench
============================

Name: riscv_lsu

Overview:
Load/store unit between the core's memory stage and the data port of the unified word-addressed RAM. It takes byte-addressed load/store requests with a RISC-V funct3 width code. It converts each request to a word index and performs byte/halfword stores as a read-modify-write. It extracts and sign- or zero-extends load data, and flags misaligned, illegal or out-of-range accesses.

Parameters:
WORD_LENGTH, 32, data and address width on both sides
NUM_MEM, 4096, number of RAM words; word index must be < NUM_MEM

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  1  core request valid
req_ready  output  1  LSU can accept a request
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RISC-V width/sign code
req_addr  input  WORD_LENGTH  byte address
req_wdata  input  WORD_LENGTH  store data, right-aligned
resp_valid  output  1  one-cycle response strobe
resp_rdata  output  WORD_LENGTH  extended load data; 0 for stores and errors
resp_err  output  1  access faulted, valid with resp_valid
mem_addr  output  WORD_LENGTH  RAM word index
mem_write_en  output  1  RAM write enable
mem_wdata  output  WORD_LENGTH  RAM write word
mem_dout  input  WORD_LENGTH  RAM read word, combinational from mem_addr

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- FSM states: IDLE, ACCESS, RESP. Reset forces IDLE and clears all registered outputs to 0.
- Outputs in reset: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_addr=0, mem_write_en=0, mem_wdata=0.
- IDLE:
  - req_ready=1.
  - On a rising edge with req_valid=1, latch we, funct3, addr and wdata.
  - If the request is legal, go to ACCESS. Otherwise set err and go to RESP.
- Legal funct3 codes:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code is an illegal request and sets err.
- Alignment: halfword accesses need addr[0]=0. Word accesses need addr[1:0]=00. A violation sets err.
- Range: word index = addr >> 2, zero-extended. Index >= NUM_MEM sets err.
- ACCESS (exactly 1 cycle):
  - mem_addr = latched word index. req_ready=0.
  - Load: select the byte or halfword from mem_dout using addr[1:0] (little-endian). Sign-extend for LB/LH, zero-extend for LBU/LHU. Register the result into resp_rdata at the edge.
  - Store: mem_wdata = mem_dout with the addressed byte lanes replaced by the low bytes of wdata; SW replaces all four lanes. mem_write_en=1 for this cycle only, so the RAM commits at the closing edge.
  - Always go to RESP.
- RESP (exactly 1 cycle):
  - resp_valid=1 and req_ready=0.
  - resp_err and resp_rdata hold their latched values.
  - Go to IDLE.
- mem_write_en is decoded from the state register and the latched we. It is never asserted outside ACCESS.
- Errored requests never reach ACCESS: no RAM write, resp_rdata=0.
- mem_addr holds its last value outside ACCESS. Only mem_write_en qualifies a write.
- Latency: accept at edge N; ACCESS in cycle N+1; resp_valid in cycle N+2; next accept possible at edge N+3. Errored requests respond in cycle N+1.
- Throughput: one request per 3 cycles (per 2 cycles when errored).
- Reset mid-operation: rst asserted in ACCESS drops mem_write_en combinationally before the next edge, so no write commits. The pending response is discarded and the FSM returns to IDLE.
- req_valid is ignored while req_ready=0. The core holds the request until accepted.

Test Plan:
1. Preload mem[1]=0x8899AABB. LB at addr 0x7 -> resp_rdata=0xFFFFFF88, err=0, resp_valid 2 cycles after accept. LBU at 0x7 -> 0x00000088. LHU at 0x4 -> 0x0000AABB. LH at 0x6 -> 0xFFFF8899.
2. mem[1]=0x8899AABB. SH wdata=0xDEAD1234 at 0x6 -> mem_write_en high for exactly one cycle, mem[1]=0x1234AABB. SB wdata=0x77 at 0x4 -> mem[1]=0x1234AA77. SW 0xCAFEF00D at 0x4 -> mem[1]=0xCAFEF00D.
3. LW at 0x5, SH at 0x3, and funct3=011 -> each gives resp_err=1 and resp_rdata=0 one cycle after accept, no mem_write_en pulse, RAM unchanged.
4. SB at addr 4*NUM_MEM (0x4000 at default) -> resp_err=1, no write. LW at 4*(NUM_MEM-1) -> err=0, returns the last word.
5. Store accepted, rst pulsed mid-ACCESS (between edges) -> mem_write_en falls immediately, target word unchanged, no resp_valid, req_ready=1 after reset.
6. req_valid held high with four back-to-back legal requests -> req_ready pattern 1,0,0,1,0,0,..., four resp_valid strobes 3 cycles apart, correct data in order.

Source files
------------

// File: rtl/riscv_lsu.sv
// Load/store unit: byte-addressed core requests to a word-addressed RAM port,
// with read-modify-write sub-word stores, load extension and fault detection.
module riscv_lsu #(
   parameter int unsigned WORD_LENGTH = 32,
   parameter int unsigned NUM_MEM     = 4096
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_we,
   input  logic [2:0]             req_funct3,
   input  logic [WORD_LENGTH-1:0] req_addr,
   input  logic [WORD_LENGTH-1:0] req_wdata,
   output logic                   resp_valid,
   output logic [WORD_LENGTH-1:0] resp_rdata,
   output logic                   resp_err,
   output logic [WORD_LENGTH-1:0] mem_addr,
   output logic                   mem_write_en,
   output logic [WORD_LENGTH-1:0] mem_wdata,
   input  logic [WORD_LENGTH-1:0] mem_dout
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_RESP   = 2'd2;

   localparam logic [WORD_LENGTH-1:0] MEM_LIMIT = WORD_LENGTH'(NUM_MEM);

   logic [1:0]             r_state;
   logic [1:0]             w_state_nxt;

   logic                   r_we;
   logic [2:0]             r_funct3;
   logic [1:0]             r_addr_lo;
   logic [WORD_LENGTH-1:0] r_wdata;
   logic [WORD_LENGTH-1:0] r_mem_addr;
   logic [WORD_LENGTH-1:0] r_resp_rdata;
   logic                   r_resp_err;

   logic [WORD_LENGTH-1:0] w_word_idx;
   logic                   w_code_bad;
   logic                   w_misalign;
   logic                   w_range_bad;
   logic                   w_req_err;
   logic                   w_accept;
   logic [7:0]             w_byte;
   logic [15:0]            w_half;
   logic [WORD_LENGTH-1:0] w_load_data;
   logic [WORD_LENGTH-1:0] w_merge;
   logic                   w_store_en;

   assign w_accept   = (r_state == S_IDLE) && req_valid;
   assign w_word_idx = {2'b00, req_addr[WORD_LENGTH-1:2]};

   // Request legality: funct3 code, natural alignment and RAM range.
   always_comb begin
      w_code_bad = 1'b0;
      case (req_funct3)
         3'b000, 3'b001, 3'b010: w_code_bad = 1'b0;
         3'b100, 3'b101:         w_code_bad = req_we;
         default:                w_code_bad = 1'b1;
      endcase
   end

   assign w_misalign  = ((req_funct3[1:0] == 2'b01) && req_addr[0])
                      || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
   assign w_range_bad = (w_word_idx >= MEM_LIMIT);
   assign w_req_err   = w_code_bad || w_misalign || w_range_bad;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (req_valid) begin
               w_state_nxt = w_req_err ? S_RESP : S_ACCESS;
            end
         end
         S_ACCESS: w_state_nxt = S_RESP;
         S_RESP:   w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // Little-endian lane selection and extension for loads.
   always_comb begin
      w_byte      = mem_dout[{r_addr_lo, 3'b000} +: 8];
      w_half      = r_addr_lo[1] ? mem_dout[31:16] : mem_dout[15:0];
      w_load_data = mem_dout;
      case (r_funct3)
         3'b000:  w_load_data = {{(WORD_LENGTH-8){w_byte[7]}}, w_byte};
         3'b001:  w_load_data = {{(WORD_LENGTH-16){w_half[15]}}, w_half};
         3'b100:  w_load_data = WORD_LENGTH'(w_byte);
         3'b101:  w_load_data = WORD_LENGTH'(w_half);
         default: w_load_data = mem_dout;
      endcase
   end

   // Store merge: replace only the addressed lanes of the current RAM word.
   always_comb begin
      w_merge = mem_dout;
      case (r_funct3[1:0])
         2'b00:   w_merge[{r_addr_lo, 3'b000} +: 8]   = r_wdata[7:0];
         2'b01:   w_merge[{r_addr_lo[1], 4'b0000} +: 16] = r_wdata[15:0];
         default: w_merge = r_wdata;
      endcase
   end

   // Request latch and response registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_we         <= 1'b0;
         r_funct3     <= 3'b000;
         r_addr_lo    <= 2'b00;
         r_wdata      <= '0;
         r_mem_addr   <= '0;
         r_resp_rdata <= '0;
         r_resp_err   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_we         <= req_we;
            r_funct3     <= req_funct3;
            r_addr_lo    <= req_addr[1:0];
            r_wdata      <= req_wdata;
            r_resp_err   <= w_req_err;
            r_resp_rdata <= '0;
            if (!w_req_err) begin
               r_mem_addr <= w_word_idx;
            end
         end else if ((r_state == S_ACCESS) && !r_we) begin
            r_resp_rdata <= w_load_data;
         end
      end
   end

   // Write strobe is state-decoded; rst gates it so an in-flight store cannot commit.
   assign w_store_en   = (r_state == S_ACCESS) && r_we;
   assign mem_write_en = w_store_en && !rst;
   assign mem_wdata    = w_store_en ? w_merge : '0;
   assign mem_addr     = r_mem_addr;

   assign req_ready  = (r_state == S_IDLE);
   assign resp_valid = (r_state == S_RESP);
   assign resp_rdata = r_resp_rdata;
   assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed self-checking bench for riscv_lsu with a behavioural word RAM.
module tb_riscv_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] mem_addr;
   logic        mem_write_en;
   logic [31:0] mem_wdata;
   logic [31:0] mem_dout;

   logic [31:0] mem [0:4095];
   logic        pre_en;
   logic [11:0] pre_addr;
   logic [31:0] pre_data;

   int n_chk  = 0;
   int n_pass = 0;

   riscv_lsu #(.WORD_LENGTH(32), .NUM_MEM(4096)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_funct3   (req_funct3),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err),
      .mem_addr     (mem_addr),
      .mem_write_en (mem_write_en),
      .mem_wdata    (mem_wdata),
      .mem_dout     (mem_dout)
   );

   always #5 clk = ~clk;

   assign mem_dout = (mem_addr < 32'd4096) ? mem[mem_addr[11:0]] : 32'h0;

   always @(posedge clk) begin
      if (pre_en) begin
         mem[pre_addr] <= pre_data;
      end else if (mem_write_en && (mem_addr < 32'd4096)) begin
         mem[mem_addr[11:0]] <= mem_wdata;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic preload(input logic [11:0] a, input logic [31:0] d);
      @(negedge clk);
      pre_en   = 1'b1;
      pre_addr = a;
      pre_data = d;
      @(negedge clk);
      pre_en   = 1'b0;
   endtask

   task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] rd, output logic er,
                          output int lat, output int wp);
      int guard;
      guard = 0;
      rd    = 32'h0;
      er    = 1'b0;
      lat   = 0;
      wp    = 0;
      @(negedge clk);
      while (!req_ready && guard < 8) begin
         @(negedge clk);
         guard++;
      end
      if (!req_ready) check("ready_timeout", 32'd0, 32'd1);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (mem_write_en) wp++;
         if (resp_valid) begin
            lat = c;
            rd  = resp_rdata;
            er  = resp_err;
            break;
         end
      end
      if (lat == 0) check("resp_timeout", 32'd0, 32'd1);
   endtask

   task automatic chk_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err);
      logic [31:0] rd;
      logic        er;
      int          lat;
      int          wp;
      run_req(we, f3, addr, wd, rd, er, lat, wp);
      check({tag, "_rdata"}, rd, exp_rd);
      check({tag, "_err"}, 32'(er), 32'(exp_err));
      check({tag, "_lat"}, 32'(lat), exp_err ? 32'd1 : 32'd2);
      check({tag, "_wpulse"}, 32'(wp), (we && !exp_err) ? 32'd1 : 32'd0);
   endtask

   logic [31:0] b2b_addr  [4];
   logic [2:0]  b2b_f3    [4];
   logic [31:0] b2b_exp   [4];
   logic [31:0] b2b_got   [4];
   int          b2b_cyc   [4];

   initial begin
      int k;
      int ri;
      int rv_cnt;

      rst        = 1'b1;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = 3'b000;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      pre_en     = 1'b0;
      pre_addr   = 12'h0;
      pre_data   = 32'h0;

      // Reset values
      #12;
      check("rst_ready",  32'(req_ready), 32'd1);
      check("rst_rvalid", 32'(resp_valid), 32'd0);
      check("rst_rdata",  resp_rdata, 32'h0);
      check("rst_err",    32'(resp_err), 32'd0);
      check("rst_maddr",  mem_addr, 32'h0);
      check("rst_mwe",    32'(mem_write_en), 32'd0);
      check("rst_mwdata", mem_wdata, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // Loads with lane select and extension
      preload(12'd0, 32'h11223344);
      preload(12'd1, 32'h8899AABB);
      chk_req("lb7",  1'b0, 3'b000, 32'h7, 32'h0, 32'hFFFFFF88, 1'b0);
      chk_req("lbu7", 1'b0, 3'b100, 32'h7, 32'h0, 32'h00000088, 1'b0);
      chk_req("lhu4", 1'b0, 3'b101, 32'h4, 32'h0, 32'h0000AABB, 1'b0);
      chk_req("lh6",  1'b0, 3'b001, 32'h6, 32'h0, 32'hFFFF8899, 1'b0);

      // Read-modify-write stores
      chk_req("sh6", 1'b1, 3'b001, 32'h6, 32'hDEAD1234, 32'h0, 1'b0);
      check("sh6_mem", mem[1], 32'h1234AABB);
      chk_req("sb4", 1'b1, 3'b000, 32'h4, 32'h00000077, 32'h0, 1'b0);
      check("sb4_mem", mem[1], 32'h1234AA77);
      chk_req("sw4", 1'b1, 3'b010, 32'h4, 32'hCAFEF00D, 32'h0, 1'b0);
      check("sw4_mem", mem[1], 32'hCAFEF00D);
      chk_req("lw4", 1'b0, 3'b010, 32'h4, 32'h0, 32'hCAFEF00D, 1'b0);

      // Misaligned and illegal requests
      chk_req("lw5_mis",  1'b0, 3'b010, 32'h5, 32'h0, 32'h0, 1'b1);
      chk_req("sh3_mis",  1'b1, 3'b001, 32'h3, 32'hFFFFFFFF, 32'h0, 1'b1);
      check("sh3_mem", mem[0], 32'h11223344);
      chk_req("f3_011",   1'b0, 3'b011, 32'h4, 32'h0, 32'h0, 1'b1);
      chk_req("sbu_ill",  1'b1, 3'b100, 32'h4, 32'h0, 32'h0, 1'b1);
      check("ill_mem", mem[1], 32'hCAFEF00D);

      // Range boundary
      preload(12'd4095, 32'hA5A50FF0);
      chk_req("sb_oor", 1'b1, 3'b000, 32'h4000, 32'h12, 32'h0, 1'b1);
      chk_req("lw_last", 1'b0, 3'b010, 32'h3FFC, 32'h0, 32'hA5A50FF0, 1'b0);
      check("last_mem", mem[4095], 32'hA5A50FF0);

      // Reset during ACCESS of a store
      preload(12'd2, 32'h00000055);
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = 3'b010;
      req_addr   = 32'h8;
      req_wdata  = 32'h12345678;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      check("mid_mwe_pre", 32'(mem_write_en), 32'd1);
      rst = 1'b1;
      #1;
      check("mid_mwe_drop", 32'(mem_write_en), 32'd0);
      check("mid_ready",    32'(req_ready), 32'd1);
      #1 rst = 1'b0;
      rv_cnt = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (resp_valid) rv_cnt++;
      end
      check("mid_no_resp", 32'(rv_cnt), 32'd0);
      check("mid_mem",     mem[2], 32'h00000055);
      check("mid_ready2",  32'(req_ready), 32'd1);

      // Back-to-back loads with req_valid held
      preload(12'd3, 32'hF0E1D2C3);
      preload(12'd4, 32'h7F800102);
      b2b_addr[0] = 32'hC;  b2b_f3[0] = 3'b010; b2b_exp[0] = 32'hF0E1D2C3;
      b2b_addr[1] = 32'hD;  b2b_f3[1] = 3'b000; b2b_exp[1] = 32'hFFFFFFD2;
      b2b_addr[2] = 32'h12; b2b_f3[2] = 3'b101; b2b_exp[2] = 32'h00007F80;
      b2b_addr[3] = 32'h10; b2b_f3[3] = 3'b001; b2b_exp[3] = 32'h00000102;
      for (int i = 0; i < 4; i++) begin
         b2b_got[i] = 32'h0;
         b2b_cyc[i] = -1;
      end
      k  = 0;
      ri = 0;
      req_we = 1'b0;
      for (int c = 0; c < 13; c++) begin
         @(negedge clk);
         if (c < 12) check($sformatf("b2b_ready%0d", c), 32'(req_ready), (c % 3 == 0) ? 32'd1 : 32'd0);
         if (resp_valid && ri < 4) begin
            b2b_got[ri] = resp_rdata;
            b2b_cyc[ri] = c;
            ri++;
         end
         if (req_ready) begin
            if (k < 4) begin
               req_valid  = 1'b1;
               req_funct3 = b2b_f3[k];
               req_addr   = b2b_addr[k];
               k++;
            end else begin
               req_valid = 1'b0;
            end
         end
      end
      req_valid = 1'b0;
      check("b2b_count", 32'(ri), 32'd4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("b2b_data%0d", i), b2b_got[i], b2b_exp[i]);
         check($sformatf("b2b_cyc%0d", i), 32'(b2b_cyc[i]), 32'(2 + 3 * i));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
